// File: rtl/clockwork_param_pkg.sv
// Shared definitions for the clockwork_param time-keeping core:
// field widths per encoding, field maxima and BCD<->binary helpers.
package clockwork_param_pkg;

   localparam int MAX_SEC  = 59;
   localparam int MAX_MIN  = 59;
   localparam int MAX_HOUR = 23;

   function automatic int hour_w(int bcd);
      return (bcd != 0) ? 6 : 5;
   endfunction

   function automatic int min_w(int bcd);
      return (bcd != 0) ? 7 : 6;
   endfunction

   function automatic int time_w(int bcd);
      return hour_w(bcd) + 2 * min_w(bcd);
   endfunction

   // Binary value 0..99 to field encoding (packed BCD or plain binary).
   function automatic logic [7:0] to_enc(int bcd, int v);
      if (bcd != 0)
         return {4'(v / 10), 4'(v % 10)};
      return 8'(v);
   endfunction

   // Field encoding back to a binary value.
   function automatic int from_enc(int bcd, logic [7:0] v);
      if (bcd != 0)
         return int'(v[7:4]) * 10 + int'(v[3:0]);
      return int'(v);
   endfunction

endpackage

// File: rtl/clockwork_param_field.sv
// One mod-(MAX+1) time field (binary or packed BCD) with load and increment.
// Ports: clk, rst (async high), inc, load, load_val -> value, wrap, is_max.
module clockwork_param_field
   import clockwork_param_pkg::*;
#(
   parameter int BCD = 0,
   parameter int W   = 6,
   parameter int MAX = 59,
   parameter int RST = 0
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         inc,
   input  logic         load,
   input  logic [W-1:0] load_val,
   output logic [W-1:0] value,
   output logic         wrap,
   output logic         is_max
);

   localparam logic [W-1:0] MAX_E = W'(to_enc(BCD, MAX));
   localparam logic [W-1:0] RST_E = W'(to_enc(BCD, RST));

   logic [W-1:0] nxt;

   if (BCD != 0) begin : g_bcd
      // Decimal digit carry: low nibble 9 rolls to 0 and bumps the tens digit.
      always_comb begin
         nxt = value;
         if (value[3:0] == 4'd9) begin
            nxt[3:0]   = 4'd0;
            nxt[W-1:4] = value[W-1:4] + (W-4)'(1);
         end else begin
            nxt[3:0] = value[3:0] + 4'd1;
         end
      end
   end else begin : g_bin
      always_comb begin
         nxt = value + W'(1);
      end
   end

   assign is_max = (value == MAX_E);
   assign wrap   = inc && is_max;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         value <= RST_E;
      else if (load)
         value <= load_val;
      else if (inc)
         value <= is_max ? '0 : nxt;
   end

endmodule

// File: rtl/clockwork_param.sv
// hh:mm:ss time-keeping core advanced by a 1-cycle tick strobe.
// Ports: clk, rst, tick, run, time_ow/time_in, inc_hour, inc_min, mode12
//        -> time_out, hour_disp, pm, day_tick, load_err.
module clockwork_param
   import clockwork_param_pkg::*;
#(
   parameter int BCD      = 0,
   parameter int RST_HOUR = 0,
   parameter int RST_MIN  = 0,
   localparam int HW      = hour_w(BCD),
   localparam int MW      = min_w(BCD),
   localparam int TIME_W  = time_w(BCD)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              tick,
   input  logic              run,
   input  logic              time_ow,
   input  logic [TIME_W-1:0] time_in,
   input  logic              inc_hour,
   input  logic              inc_min,
   input  logic              mode12,
   output logic [TIME_W-1:0] time_out,
   output logic [HW-1:0]     hour_disp,
   output logic              pm,
   output logic              day_tick,
   output logic              load_err
);

   logic [HW-1:0] hour, in_h;
   logic [MW-1:0] min, sec, in_m, in_s;
   logic sec_wrap, min_wrap, hour_wrap;
   logic sec_max, min_max, hour_max;
   logic valid, load_ok, set_h, set_m, tk;
   logic unused_max;

   assign {in_h, in_m, in_s} = time_in;

   // Range check on decoded values; BCD also needs every units digit <= 9.
   always_comb begin
      valid = (from_enc(BCD, 8'(in_s)) <= MAX_SEC)
           && (from_enc(BCD, 8'(in_m)) <= MAX_MIN)
           && (from_enc(BCD, 8'(in_h)) <= MAX_HOUR);
      if (BCD != 0)
         valid = valid && (in_s[3:0] <= 4'd9)
                       && (in_m[3:0] <= 4'd9)
                       && (in_h[3:0] <= 4'd9);
   end

   // time_ow wins over set strobes, which win over tick.
   assign load_ok = time_ow && valid;
   assign set_h   = !time_ow && inc_hour;
   assign set_m   = !time_ow && inc_min;
   assign tk      = tick && run && !time_ow && !inc_hour && !inc_min;

   clockwork_param_field #(
      .BCD(BCD), .W(MW), .MAX(MAX_SEC), .RST(0)
   ) u_sec (
      .clk(clk), .rst(rst), .inc(tk), .load(load_ok),
      .load_val(in_s), .value(sec), .wrap(sec_wrap),
      .is_max(sec_max)
   );

   // Minute set strobe never carries into the hour: only sec_wrap does.
   clockwork_param_field #(
      .BCD(BCD), .W(MW), .MAX(MAX_MIN), .RST(RST_MIN)
   ) u_min (
      .clk(clk), .rst(rst), .inc(sec_wrap || set_m),
      .load(load_ok), .load_val(in_m), .value(min),
      .wrap(min_wrap), .is_max(min_max)
   );

   clockwork_param_field #(
      .BCD(BCD), .W(HW), .MAX(MAX_HOUR), .RST(RST_HOUR)
   ) u_hour (
      .clk(clk), .rst(rst),
      .inc((sec_wrap && min_wrap) || set_h),
      .load(load_ok), .load_val(in_h), .value(hour),
      .wrap(hour_wrap), .is_max(hour_max)
   );

   assign unused_max = sec_max & min_max & hour_max;
   assign time_out   = {hour, min, sec};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         day_tick <= 1'b0;
         load_err <= 1'b0;
      end else begin
         day_tick <= sec_wrap && min_wrap && hour_wrap;
         load_err <= time_ow && !valid;
      end
   end

   // 12 h view of the stored 24 h hour.
   int hb, dh;
   always_comb begin
      hb = from_enc(BCD, 8'(hour));
      dh = hb;
      if (mode12) begin
         if (hb == 0)
            dh = 12;
         else if (hb > 12)
            dh = hb - 12;
      end
      hour_disp = HW'(to_enc(BCD, dh));
      pm        = (hb >= 12);
   end

endmodule

// File: tb/tb_clockwork_param.sv
// Self-checking bench: a binary (BCD=0) and a BCD (BCD=1) instance
// compared against a seconds-of-day reference model.
module tb_clockwork_param;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic tick = 1'b0, run = 1'b1, mode12 = 1'b0;
   logic inc_hour = 1'b0, inc_min = 1'b0;
   logic ow0 = 1'b0, ow1 = 1'b0;
   logic [16:0] tin0 = '0;
   logic [19:0] tin1 = '0;
   logic [16:0] to0;
   logic [19:0] to1;
   logic [4:0]  hd0;
   logic [5:0]  hd1;
   logic pm0, pm1, day0, day1, err0, err1;

   int checks = 0;
   int failures = 0;

   int mh[2];
   int mm[2];
   int ms[2];
   bit mday[2];
   bit merr[2];

   always #5 clk = ~clk;

   clockwork_param #(.BCD(0)) dut0 (
      .clk(clk), .rst(rst), .tick(tick), .run(run),
      .time_ow(ow0), .time_in(tin0), .inc_hour(inc_hour),
      .inc_min(inc_min), .mode12(mode12), .time_out(to0),
      .hour_disp(hd0), .pm(pm0), .day_tick(day0), .load_err(err0)
   );

   clockwork_param #(.BCD(1), .RST_HOUR(19), .RST_MIN(45)) dut1 (
      .clk(clk), .rst(rst), .tick(tick), .run(run),
      .time_ow(ow1), .time_in(tin1), .inc_hour(inc_hour),
      .inc_min(inc_min), .mode12(mode12), .time_out(to1),
      .hour_disp(hd1), .pm(pm1), .day_tick(day1), .load_err(err1)
   );

   function automatic int bcd(int v);
      return (v / 10) * 16 + v % 10;
   endfunction

   function automatic logic [19:0] enc(int d, int h, int m, int s);
      if (d == 1)
         return {6'(bcd(h)), 7'(bcd(m)), 7'(bcd(s))};
      return {3'b0, 5'(h), 6'(m), 6'(s)};
   endfunction

   task automatic reset_model();
      mh[0] = 0;  mm[0] = 0;  ms[0] = 0;
      mh[1] = 19; mm[1] = 45; ms[1] = 0;
      for (int d = 0; d < 2; d++) begin
         mday[d] = 1'b0;
         merr[d] = 1'b0;
      end
   endtask

   task automatic decode(input int d, input logic [19:0] raw,
                         output bit ok, output int h,
                         output int m, output int s);
      int hl, ml, sl;
      if (d == 1) begin
         hl = int'(raw[17:14]); ml = int'(raw[10:7]); sl = int'(raw[3:0]);
         h = int'(raw[19:18]) * 10 + hl;
         m = int'(raw[13:11]) * 10 + ml;
         s = int'(raw[6:4]) * 10 + sl;
         ok = hl <= 9 && ml <= 9 && sl <= 9;
      end else begin
         h = int'(raw[16:12]); m = int'(raw[11:6]); s = int'(raw[5:0]);
         ok = 1'b1;
      end
      ok = ok && h <= 23 && m <= 59 && s <= 59;
   endtask

   task automatic model_edge();
      bit ow, ok;
      logic [19:0] raw;
      int h, m, s, t;
      for (int d = 0; d < 2; d++) begin
         ow  = (d == 1) ? ow1 : ow0;
         raw = (d == 1) ? tin1 : {3'b0, tin0};
         mday[d] = 1'b0;
         merr[d] = 1'b0;
         if (ow) begin
            decode(d, raw, ok, h, m, s);
            if (ok) begin
               mh[d] = h; mm[d] = m; ms[d] = s;
            end else begin
               merr[d] = 1'b1;
            end
         end else if (inc_hour || inc_min) begin
            if (inc_hour) mh[d] = (mh[d] + 1) % 24;
            if (inc_min)  mm[d] = (mm[d] + 1) % 60;
         end else if (tick && run) begin
            t = mh[d] * 3600 + mm[d] * 60 + ms[d] + 1;
            if (t == 86400) begin
               mday[d] = 1'b1;
               t = 0;
            end
            mh[d] = t / 3600;
            mm[d] = (t / 60) % 60;
            ms[d] = t % 60;
         end
      end
   endtask

   task automatic chk(input string tag, input int d,
                      input logic [19:0] got, input logic [19:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s dut%0d got=%0h exp=%0h", tag, d, got, exp);
      end
   endtask

   task automatic check_all(input string tag);
      int dh;
      for (int d = 0; d < 2; d++) begin
         dh = mh[d];
         if (mode12) begin
            if (dh == 0) dh = 12;
            else if (dh > 12) dh = dh - 12;
         end
         if (d == 0) begin
            chk({tag, "_time"}, d, {3'b0, to0}, enc(0, mh[0], mm[0], ms[0]));
            chk({tag, "_disp"}, d, {15'b0, hd0}, {15'b0, 5'(dh)});
            chk({tag, "_pm"},   d, {19'b0, pm0}, {19'b0, mh[0] >= 12});
            chk({tag, "_day"},  d, {19'b0, day0}, {19'b0, mday[0]});
            chk({tag, "_err"},  d, {19'b0, err0}, {19'b0, merr[0]});
         end else begin
            chk({tag, "_time"}, d, to1, enc(1, mh[1], mm[1], ms[1]));
            chk({tag, "_disp"}, d, {14'b0, hd1}, {14'b0, 6'(bcd(dh))});
            chk({tag, "_pm"},   d, {19'b0, pm1}, {19'b0, mh[1] >= 12});
            chk({tag, "_day"},  d, {19'b0, day1}, {19'b0, mday[1]});
            chk({tag, "_err"},  d, {19'b0, err1}, {19'b0, merr[1]});
         end
      end
   endtask

   task automatic step(input string tag);
      @(posedge clk);
      #1;
      model_edge();
      tick = 1'b0; ow0 = 1'b0; ow1 = 1'b0;
      inc_hour = 1'b0; inc_min = 1'b0;
      check_all(tag);
   endtask

   task automatic load_both(input int h, input int m, input int s);
      ow0 = 1'b1; tin0 = 17'(enc(0, h, m, s));
      ow1 = 1'b1; tin1 = enc(1, h, m, s);
   endtask

   int hours[6] = '{0, 1, 11, 12, 13, 23};
   int rh, rm, rs;

   initial begin
      reset_model();
      repeat (2) @(posedge clk);
      #1;
      check_all("reset");
      rst = 1'b0;

      load_both(23, 59, 58); step("load_2359");
      tick = 1'b1; step("tick_59");
      tick = 1'b1; step("day_wrap");
      step("day_clear");

      load_both(9, 59, 59); step("load_0959");
      tick = 1'b1; step("to_1000");
      load_both(19, 59, 59); step("load_1959");
      tick = 1'b1; step("to_2000");

      ow0 = 1'b1; tin0 = {5'd24, 6'd0, 6'd0};
      ow1 = 1'b1; tin1 = {6'h24, 7'h00, 7'h00};
      tick = 1'b1;
      step("bad_24");
      ow0 = 1'b1; tin0 = {5'd12, 6'd60, 6'd0};
      ow1 = 1'b1; tin1 = {6'h12, 7'h5A, 7'h00};
      step("bad_min");
      step("err_clear");

      load_both(8, 0, 0); tick = 1'b1; inc_min = 1'b1; step("ow_prio");
      load_both(10, 59, 30); step("load_1059");
      inc_min = 1'b1; tick = 1'b1; step("inc_min_nocarry");
      inc_hour = 1'b1; inc_min = 1'b1; step("inc_both");

      mode12 = 1'b1;
      foreach (hours[i]) begin
         load_both(hours[i], 0, 0);
         step("mode12");
      end
      mode12 = 1'b0;
      step("mode24");

      run = 1'b0;
      repeat (5) begin
         tick = 1'b1; step("paused");
      end
      run = 1'b1;
      repeat (3) begin
         tick = 1'b1; step("running");
      end
      tick = 1'b1;
      rst = 1'b1;
      #2;
      reset_model();
      check_all("async_rst");
      tick = 1'b0;
      #1 rst = 1'b0;
      step("post_rst");

      repeat (400) begin
         run    = ($urandom_range(0, 3) != 0);
         mode12 = 1'($urandom_range(0, 1));
         tick   = ($urandom_range(0, 3) != 0);
         inc_hour = ($urandom_range(0, 15) == 0);
         inc_min  = ($urandom_range(0, 15) == 0);
         if ($urandom_range(0, 19) == 0) begin
            if ($urandom_range(0, 1) == 0) begin
               rh = 23; rm = 59; rs = $urandom_range(55, 59);
            end else begin
               rh = $urandom_range(0, 23);
               rm = $urandom_range(0, 59);
               rs = $urandom_range(0, 59);
            end
            load_both(rh, rm, rs);
         end else if ($urandom_range(0, 29) == 0) begin
            ow0 = 1'b1; tin0 = 17'($urandom);
            ow1 = 1'b1; tin1 = 20'($urandom);
         end
         step("random");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
